oled_ssd1306_ctrl: RTL
======================

Name: oled_ssd1306_ctrl

Overview:
- Parametrised successor to the Arduboy OLED SPI receiver.
- Deserialises the SSD1306 4-wire SPI stream on one system clock, using a bit-valid strobe from the pin synchroniser.
- Parses full commands, including multi-byte arguments, and honours horizontal, vertical and page addressing modes.
- Writes GDDRAM bytes into an internal frame buffer, which the video scanout reads on the same clock.

Parameters:
- WIDTH, 128, display columns, power of two ≤ 128.
- HEIGHT, 64, display rows, multiple of 8, ≤ 64.
- PAGES, HEIGHT/8, derived, do not override.
- ADDR_W, $clog2(WIDTH*PAGES), frame-buffer address width.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- oled_cs_n  in  1  chip select, active low.
- oled_bit_valid  in  1  one-cycle strobe: sample oled_data/oled_dc this cycle.
- oled_dc  in  1  1 = data, 0 = command; sampled with the 8th bit.
- oled_data  in  1  serial bit, MSB first.
- read_addr  in  ADDR_W  scanout address, {page, column}.
- read_data  out  8  frame-buffer byte, bit0 = top row of page.
- invert_video  out  1  0xA6/0xA7 state.
- display_on  out  1  0xAE/0xAF state.
- contrast  out  8  0x81 argument.
- frame_done  out  1  one-cycle pulse on frame wrap.

Behaviour:
- Reset values: invert_video 0, display_on 0, contrast 0x7F, frame_done 0, read_data 0.
- Reset values of internal state: mode = page (2), col_start 0, col_end WIDTH-1, page_start 0, page_end PAGES-1, col/page pointers 0, bit counter 0, parser IDLE.
- Frame-buffer contents are not cleared by reset.
- Shift: on oled_bit_valid with oled_cs_n low, shift in {sr[6:0], oled_data} and increment the 3-bit counter.
- A byte completes when the counter is 7. oled_dc is sampled in that same cycle.
- oled_cs_n high: counter forced to 0 and parser to IDLE; a partial byte is discarded.
- Parser states:
  - IDLE, ARG1, ARG2.
  - Commands taking one argument go IDLE→ARG1: 0x20 mode, 0x81 contrast. 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB and 0x8D also take one argument, which is consumed and ignored.
  - Commands taking two arguments go IDLE→ARG1→ARG2: 0x21 column range, 0x22 page range.
  - All other commands are single-byte.
- A data byte (dc=1) arriving in ARG1/ARG2 aborts the pending command; the parser returns to IDLE and the byte is written as data.
- Command effects:
  - 0x20: mode = arg[1:0]; value 3 is treated as 2.
  - 0x21: col_start = arg1, col_end = arg2, masked to $clog2(WIDTH) bits; column pointer = col_start on arg1.
  - 0x22: page_start = arg1, page_end = arg2, masked to 3 bits (then to PAGES range); page pointer = page_start on arg1.
  - 0xB0–0xB7: page pointer = cmd[2:0].
  - 0x00–0x0F: column pointer low nibble.
  - 0x10–0x1F: column pointer high nibble.
  - 0xA6/0xA7: invert_video = cmd[0].
  - 0xAE/0xAF: display_on = cmd[0].
- Data byte: write mem[{page, col}] in the completion cycle, then advance the pointers.
  - Horizontal: col++. At col_end, col = col_start and page++. At page_end, page = page_start and frame_done pulses next cycle.
  - Vertical: page++. At page_end, page = page_start and col++. At col_end, col = col_start and frame_done pulses.
  - Page: col++; at WIDTH-1, col = 0 and the page is unchanged; frame_done never pulses.
  - Pointer < start or > end: increment freely until the wrap at the field maximum, then the range rules apply.
- Read: read_data = mem[read_addr] registered, latency 1 cycle. A same-cycle write and read to the same address returns the old data.
- Mid-byte reset: all state returns to reset values; the next byte starts at bit 0.

Test Plan:
- Reset, then shift 0xA7 with dc=0 → invert_video=1 one cycle after the 8th bit. Then 0xAF → display_on=1. Then 0x81, 0x40 → contrast=0x40.
- Send 0x20,0x00; 0x21,0x00,0x7F; 0x22,0x00,0x07; then 1024 data bytes with value = index[7:0] → read_addr 0x3FF returns 0xFF one cycle later, and frame_done pulses exactly once, after byte 1024.
- Vertical mode with 0x21,0x02,0x03 and 0x22,0x00,0x01; write bytes A,B,C,D,E → A at {0,2}, B at {1,2}, C at {0,3}, D at {1,3}, frame_done pulse, then E at {0,2}.
- Page mode: send 0xB3, 0x05, 0x17; write 0x5A → mem[{3,0x75}]=0x5A. Write 11 more bytes → the 12th lands at {3,0x00}, with no frame_done.
- Deassert oled_cs_n after 4 bits, then send 0xA7 → invert_video=1, with no stray write. Send 0x81 then a dc=1 byte 0x33 → contrast unchanged, and 0x33 is written at the current pointer.
- Assert reset after 5 bits of a byte; release, send 0xAF → display_on=1, and mode reads as page (page-mode wrap rule holds).

Source files
------------

// File: rtl/oled_ssd1306_ctrl.sv
// SSD1306 4-wire SPI receiver: deserialises bytes, parses commands and writes GDDRAM
// bytes into a frame buffer that the scanout reads on the same clock.
module oled_ssd1306_ctrl #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 64,
    parameter int PAGES  = HEIGHT / 8,
    parameter int ADDR_W = $clog2(WIDTH * PAGES)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              oled_cs_n,
    input  logic              oled_bit_valid,
    input  logic              oled_dc,
    input  logic              oled_data,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [7:0]        read_data,
    output logic              invert_video,
    output logic              display_on,
    output logic [7:0]        contrast,
    output logic              frame_done
);
    localparam int COL_W = $clog2(WIDTH);

    typedef enum logic [1:0] {P_IDLE, P_ARG1, P_ARG2} parse_t;

    parse_t         state;
    logic [6:0]     sr;
    logic [2:0]     bit_cnt;
    logic [7:0]     cmd_q;
    logic [1:0]     mode;
    logic [COL_W-1:0] col_start, col_end, col_ptr;
    logic [2:0]     page_start, page_end, page_ptr;
    logic [7:0]     mem [WIDTH*PAGES];

    logic             byte_done, is_data;
    logic [7:0]       rx_byte, col_ext;
    logic [COL_W-1:0] col_arg, col_inc;
    logic [2:0]       page_arg, page_inc;
    logic [ADDR_W-1:0] wr_addr;

    function automatic logic [2:0] page_clamp(input logic [2:0] p);
        return (int'(p) >= PAGES) ? 3'(PAGES - 1) : p;
    endfunction

    always_comb begin
        byte_done = !oled_cs_n && oled_bit_valid && (bit_cnt == 3'd7);
        is_data   = byte_done && oled_dc;
        rx_byte   = {sr, oled_data};
        col_ext   = 8'(col_ptr);
        col_arg   = rx_byte[COL_W-1:0];
        page_arg  = page_clamp(rx_byte[2:0]);
        col_inc   = col_ptr + COL_W'(1);
        page_inc  = (page_ptr == 3'(PAGES - 1)) ? 3'd0 : page_ptr + 3'd1;
        wr_addr   = ADDR_W'({page_ptr, col_ptr});
    end

    // Parser, pointer and register state; outputs are registered here.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= P_IDLE;
            sr           <= '0;
            bit_cnt      <= '0;
            cmd_q        <= '0;
            mode         <= 2'd2;
            col_start    <= '0;
            col_end      <= COL_W'(WIDTH - 1);
            col_ptr      <= '0;
            page_start   <= '0;
            page_end     <= 3'(PAGES - 1);
            page_ptr     <= '0;
            invert_video <= 1'b0;
            display_on   <= 1'b0;
            contrast     <= 8'h7F;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (oled_cs_n) begin
                bit_cnt <= '0;
                state   <= P_IDLE;
            end else if (oled_bit_valid) begin
                sr      <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (oled_dc) begin
                        state <= P_IDLE;
                        case (mode)
                            2'd0: begin
                                if (col_ptr == col_end) begin
                                    col_ptr <= col_start;
                                    if (page_ptr == page_end) begin
                                        page_ptr   <= page_start;
                                        frame_done <= 1'b1;
                                    end else begin
                                        page_ptr <= page_inc;
                                    end
                                end else begin
                                    col_ptr <= col_inc;
                                end
                            end
                            2'd1: begin
                                if (page_ptr == page_end) begin
                                    page_ptr <= page_start;
                                    if (col_ptr == col_end) begin
                                        col_ptr    <= col_start;
                                        frame_done <= 1'b1;
                                    end else begin
                                        col_ptr <= col_inc;
                                    end
                                end else begin
                                    page_ptr <= page_inc;
                                end
                            end
                            default: col_ptr <= col_inc;
                        endcase
                    end else begin
                        case (state)
                            P_IDLE: begin
                                case (rx_byte)
                                    8'h20, 8'h81, 8'h21, 8'h22, 8'hA8, 8'hD3, 8'hD5,
                                    8'hD9, 8'hDA, 8'hDB, 8'h8D: begin
                                        cmd_q <= rx_byte;
                                        state <= P_ARG1;
                                    end
                                    8'hA6, 8'hA7: invert_video <= rx_byte[0];
                                    8'hAE, 8'hAF: display_on   <= rx_byte[0];
                                    default: begin
                                        if (rx_byte[7:3] == 5'b10110)
                                            page_ptr <= page_arg;
                                        else if (rx_byte[7:4] == 4'h0)
                                            col_ptr <= COL_W'({col_ext[7:4], rx_byte[3:0]});
                                        else if (rx_byte[7:4] == 4'h1)
                                            col_ptr <= COL_W'({rx_byte[3:0], col_ext[3:0]});
                                    end
                                endcase
                            end
                            P_ARG1: begin
                                state <= P_IDLE;
                                case (cmd_q)
                                    8'h20: mode <= (rx_byte[1:0] == 2'd3) ? 2'd2 : rx_byte[1:0];
                                    8'h81: contrast <= rx_byte;
                                    8'h21: begin
                                        col_start <= col_arg;
                                        col_ptr   <= col_arg;
                                        state     <= P_ARG2;
                                    end
                                    8'h22: begin
                                        page_start <= page_arg;
                                        page_ptr   <= page_arg;
                                        state      <= P_ARG2;
                                    end
                                    default: ;
                                endcase
                            end
                            default: begin
                                state <= P_IDLE;
                                if (cmd_q == 8'h21) col_end  <= col_arg;
                                if (cmd_q == 8'h22) page_end <= page_arg;
                            end
                        endcase
                    end
                end
            end
        end
    end

    // Frame buffer is deliberately not cleared by reset.
    always_ff @(posedge clk_sys) begin
        if (!reset && is_data)
            mem[wr_addr] <= rx_byte;
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            read_data <= 8'h00;
        else
            read_data <= mem[read_addr];
    end
endmodule
